// File: rtl/ps2_mouse_cursor.sv
// PS/2 mouse packet framer and clamped cursor integrator.
// Optional MOUSE_TIMEOUT_EN drops stale partial packets.
module ps2_mouse_cursor #(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  output logic [9:0] cursor_x,
  output logic [8:0] cursor_y,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       packet_valid,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    WAIT_B1,
    WAIT_B2,
    WAIT_B3,
    COMMIT
  } state_t;

  state_t state;

  logic [6:0] hdr;
  logic [7:0] b2;
  logic [7:0] b3;

  logic               timeout;
  logic               take_b1;
  logic [8:0]         dx_eff;
  logic [8:0]         dy_eff;
  logic signed [11:0] x_next;
  logic signed [11:0] y_next;
  logic [9:0]         x_clamp;
  logic [8:0]         y_clamp;

`ifdef MOUSE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] idle_cnt;
  logic          mid_pkt;

  assign mid_pkt = (state == WAIT_B2) ||
                   (state == WAIT_B3);
  assign timeout = mid_pkt &&
    (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (rx_data_en || !mid_pkt || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign take_b1 = rx_data_en &&
    ((state == WAIT_B1) || (state == COMMIT) || timeout);

  always_comb begin
    dx_eff = hdr[5] ? 9'd0 : {hdr[3], b2};
    dy_eff = hdr[6] ? 9'd0 : {hdr[4], b3};
    x_next = $signed({2'b00, cursor_x}) +
             $signed({{3{dx_eff[8]}}, dx_eff});
    y_next = $signed({3'b000, cursor_y}) -
             $signed({{3{dy_eff[8]}}, dy_eff});
    if (x_next < 12'sd0) begin
      x_clamp = '0;
    end else if (x_next > X_MAX) begin
      x_clamp = 10'(X_MAX);
    end else begin
      x_clamp = x_next[9:0];
    end
    if (y_next < 12'sd0) begin
      y_clamp = '0;
    end else if (y_next > Y_MAX) begin
      y_clamp = 9'(Y_MAX);
    end else begin
      y_clamp = y_next[8:0];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_B1;
      hdr          <= '0;
      b2           <= '0;
      b3           <= '0;
      cursor_x     <= 10'(X_INIT);
      cursor_y     <= 9'(Y_INIT);
      buttons      <= '0;
      dx           <= '0;
      dy           <= '0;
      packet_valid <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      sync_err     <= 1'b0;

      if (state == COMMIT) begin
        cursor_x     <= x_clamp;
        cursor_y     <= y_clamp;
        buttons      <= hdr[2:0];
        dx           <= dx_eff;
        dy           <= dy_eff;
        packet_valid <= 1'b1;
        state        <= WAIT_B1;
      end

      if (timeout) begin
        sync_err <= 1'b1;
        state    <= WAIT_B1;
      end

      if (take_b1) begin
        if (rx_data[3]) begin
          hdr   <= {rx_data[7:4], rx_data[2:0]};
          state <= WAIT_B2;
        end else begin
          sync_err <= 1'b1;
          state    <= WAIT_B1;
        end
      end else if (rx_data_en && state == WAIT_B2) begin
        b2    <= rx_data;
        state <= WAIT_B3;
      end else if (rx_data_en && state == WAIT_B3) begin
        b3    <= rx_data;
        state <= COMMIT;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Testbench for ps2_mouse_cursor.
// Directed and random packets against a cursor model.
module tb_ps2_mouse_cursor;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_en = 1'b0;
  logic [9:0] cursor_x;
  logic [8:0] cursor_y;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       packet_valid;
  logic       sync_err;

  int n_cmp = 0;
  int n_err = 0;

  int ref_x = 320;
  int ref_y = 240;
  int ref_dx = 0;
  int ref_dy = 0;
  int ref_btn = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_mouse_cursor #(.TIMEOUT_CYCLES(100)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_data_en  (rx_data_en),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .buttons     (buttons),
    .dx          (dx),
    .dy          (dy),
    .packet_valid(packet_valid),
    .sync_err    (sync_err)
  );

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic void model_packet(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] c);
    int mx;
    int my;
    mx = a[6] ? 0 : (int'(b) - (a[4] ? 256 : 0));
    my = a[7] ? 0 : (int'(c) - (a[5] ? 256 : 0));
    ref_x   = clampi(ref_x + mx, 639);
    ref_y   = clampi(ref_y - my, 479);
    ref_dx  = mx;
    ref_dy  = my;
    ref_btn = int'(a[2:0]);
  endfunction

  function automatic void model_reset();
    ref_x   = 320;
    ref_y   = 240;
    ref_dx  = 0;
    ref_dy  = 0;
    ref_btn = 0;
  endfunction

  function automatic logic [41:0] exp_vec(input logic pv,
                                          input logic se);
    return {10'(ref_x), 9'(ref_y), 3'(ref_btn),
            9'(ref_dx), 9'(ref_dy), pv, se};
  endfunction

  function automatic logic [41:0] obs_vec();
    return {cursor_x, cursor_y, buttons, dx, dy,
            packet_valid, sync_err};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLOCK_50);
    rx_data    = b;
    rx_data_en = 1'b1;
    @(negedge CLOCK_50);
    rx_data_en = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] a,
                             input logic [7:0] b,
                             input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    #3;
    reset_n    = 1'b0;
    rx_data_en = 1'b0;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_err++;
      $display("FAIL reset_low got %h want %h",
               obs_vec(), exp_vec(1'b0, 1'b0));
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge CLOCK_50);
      n_cmp++;
      if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL reset_idle got %h want %h",
                 obs_vec(), exp_vec(1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_packet(8'h09, 8'h05, 8'h03);
    n_cmp++;
    if (packet_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_early pv got %b want 0",
               packet_valid);
    end
    model_packet(8'h09, 8'h05, 8'h03);
    @(negedge CLOCK_50);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
      n_err++;
      $display("FAIL basic_pkt got %h want %h",
               obs_vec(), exp_vec(1'b1, 1'b0));
    end
    n_cmp++;
    if ({cursor_x, cursor_y} !== {10'd325, 9'd237}) begin
      n_err++;
      $display("FAIL basic_xy got %0d,%0d want 325,237",
               cursor_x, cursor_y);
    end
    @(negedge CLOCK_50);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_err++;
      $display("FAIL basic_hold got %h want %h",
               obs_vec(), exp_vec(1'b0, 1'b0));
    end
  endtask

  task automatic test_clamp();
    logic [7:0] pk [9][3];
    pk = '{'{8'h08, 8'h7F, 8'h00}, '{8'h08, 8'h7F, 8'h00},
           '{8'h08, 8'h7F, 8'h00}, '{8'h28, 8'h00, 8'h80},
           '{8'h28, 8'h00, 8'h80}, '{8'h08, 8'h00, 8'h7F},
           '{8'h08, 8'h00, 8'h7F}, '{8'h08, 8'h00, 8'h7F},
           '{8'h18, 8'h00, 8'h00}};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        do_reset();
      end
      send_packet(pk[i][0], pk[i][1], pk[i][2]);
      model_packet(pk[i][0], pk[i][1], pk[i][2]);
      @(negedge CLOCK_50);
      n_cmp++;
      if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
        n_err++;
        $display("FAIL clamp_%0d got %h want %h",
                 i, obs_vec(), exp_vec(1'b1, 1'b0));
      end
    end
  endtask

  task automatic test_resync();
    do_reset();
    send_byte(8'h05);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b0, 1'b1)) begin
      n_err++;
      $display("FAIL resync_err got %h want %h",
               obs_vec(), exp_vec(1'b0, 1'b1));
    end
    @(negedge CLOCK_50);
    n_cmp++;
    if (sync_err !== 1'b0) begin
      n_err++;
      $display("FAIL resync_width sync_err got %b want 0",
               sync_err);
    end
    send_packet(8'h08, 8'h01, 8'h01);
    model_packet(8'h08, 8'h01, 8'h01);
    @(negedge CLOCK_50);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
      n_err++;
      $display("FAIL resync_pkt got %h want %h",
               obs_vec(), exp_vec(1'b1, 1'b0));
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_packet(8'h48, 8'h10, 8'h02);
    model_packet(8'h48, 8'h10, 8'h02);
    @(negedge CLOCK_50);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
      n_err++;
      $display("FAIL ovf_x got %h want %h",
               obs_vec(), exp_vec(1'b1, 1'b0));
    end
    send_packet(8'hBD, 8'hF0, 8'h33);
    model_packet(8'hBD, 8'hF0, 8'h33);
    @(negedge CLOCK_50);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
      n_err++;
      $display("FAIL ovf_y got %h want %h",
               obs_vec(), exp_vec(1'b1, 1'b0));
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'h0F);
    send_byte(8'h40);
    do_reset();
    send_packet(8'h09, 8'h02, 8'h02);
    model_packet(8'h09, 8'h02, 8'h02);
    @(negedge CLOCK_50);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
      n_err++;
      $display("FAIL mid_reset got %h want %h",
               obs_vec(), exp_vec(1'b1, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bs [6];
    for (int i = 0; i < 6; i++) begin
      bs[i] = 8'($urandom);
    end
    bs[0][3] = 1'b1;
    bs[3][3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      if (i == 4) begin
        model_packet(bs[0], bs[1], bs[2]);
        n_cmp++;
        if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
          n_err++;
          $display("FAIL b2b_first got %h want %h",
                   obs_vec(), exp_vec(1'b1, 1'b0));
        end
      end
      rx_data    = bs[i];
      rx_data_en = 1'b1;
    end
    @(negedge CLOCK_50);
    rx_data_en = 1'b0;
    model_packet(bs[3], bs[4], bs[5]);
    @(negedge CLOCK_50);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
      n_err++;
      $display("FAIL b2b_second got %h want %h",
               obs_vec(), exp_vec(1'b1, 1'b0));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      rx_data    = (i == 3) ? 8'h12 : bs[i];
      rx_data_en = 1'b1;
    end
    @(negedge CLOCK_50);
    rx_data_en = 1'b0;
    model_packet(bs[0], bs[1], bs[2]);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b1, 1'b1)) begin
      n_err++;
      $display("FAIL b2b_commit_bad got %h want %h",
               obs_vec(), exp_vec(1'b1, 1'b1));
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(7) == 0) begin
        a = 8'($urandom);
        a[3] = 1'b0;
        send_byte(a);
        n_cmp++;
        if (obs_vec() !== exp_vec(1'b0, 1'b1)) begin
          n_err++;
          $display("FAIL rnd_bad_%0d got %h want %h",
                   k, obs_vec(), exp_vec(1'b0, 1'b1));
        end
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        a[3] = 1'b1;
        if ($urandom_range(3) != 0) begin
          a[7:6] = 2'b00;
        end
        send_packet(a, b, c);
        model_packet(a, b, c);
        @(negedge CLOCK_50);
        n_cmp++;
        if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
          n_err++;
          $display("FAIL rnd_pkt_%0d got %h want %h",
                   k, obs_vec(), exp_vec(1'b1, 1'b0));
        end
      end
    end
  endtask

`ifdef MOUSE_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    do_reset();
    send_byte(8'h08);
    seen = 0;
    for (int i = 0; i < 150 && seen == 0; i++) begin
      @(negedge CLOCK_50);
      if (sync_err === 1'b1) begin
        seen = 1;
      end
    end
    n_cmp++;
    if (seen != 1) begin
      n_err++;
      $display("FAIL timeout_err got %0d want 1", seen);
    end
    send_packet(8'h09, 8'h01, 8'h01);
    model_packet(8'h09, 8'h01, 8'h01);
    @(negedge CLOCK_50);
    n_cmp++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
      n_err++;
      $display("FAIL timeout_pkt got %h want %h",
               obs_vec(), exp_vec(1'b1, 1'b0));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_resync();
    test_overflow();
    test_mid_reset();
    test_back_to_back();
    test_random();
`ifdef MOUSE_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
